// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: round-robin two-port sequencer in front of the byte-addressed 4 KiB data memory
module dm_port_arbiter #(
  parameter int MEM_BYTES = 4096,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [1:0]  req0_size,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [1:0]  req1_size,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic        mem_wren,
  output logic        mem_sb,
  output logic        mem_lb,
  output logic        mem_lbu,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  input  logic [31:0] mem_readData
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic last_grant, gid, l_we, l_err, win, take, acc, c_we, c_err, rsp_hs;
  logic [1:0] l_size, c_size;
  logic [31:0] l_addr, l_wdata, l_rdata, c_addr, c_wdata;
  // pick the winner and present the winning command; ready is forced low while reset is held
  always_comb begin
    win = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    req0_ready = rst_n & (state == IDLE) & req0_valid & ~win;
    req1_ready = rst_n & (state == IDLE) & req1_valid & win;
    take = req0_ready | req1_ready;
    c_we = win ? req1_we : req0_we;
    c_size = win ? req1_size : req0_size;
    c_addr = win ? req1_addr : req0_addr;
    c_wdata = win ? req1_wdata : req0_wdata;
    c_err = (c_addr >= 32'(MEM_BYTES)) | (c_size == 2'b11) |
            (CHECK_ALIGN & (c_size == 2'b10) & (c_addr[1:0] != 2'b00));
  end
  // next state: one access cycle per grant, then hold the response until it is taken
  always_comb begin
    state_nx = state;
    rsp_hs = gid ? rsp1_ready : rsp0_ready;
    case (state)
      IDLE:    state_nx = take ? ACCESS : IDLE;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = rsp_hs ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // command latch on grant and read-data capture at the end of the access cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      gid <= 1'b0;
      l_we <= 1'b0;
      l_size <= 2'b00;
      l_addr <= '0;
      l_wdata <= '0;
      l_err <= 1'b0;
      l_rdata <= '0;
    end else begin
      if (take) begin
        gid <= win;
        last_grant <= win;
        l_we <= c_we;
        l_size <= c_size;
        l_addr <= c_addr;
        l_wdata <= c_wdata;
        l_err <= c_err;
      end
      if (acc) l_rdata <= (~l_we & ~l_err) ? mem_readData : '0;
    end
  end
  assign acc = state == ACCESS;
  assign mem_wren = acc & l_we & ~l_err;
  assign mem_sb = acc & l_we & ~l_size[1];
  assign mem_lb = acc & ~l_we & (l_size == 2'b00);
  assign mem_lbu = acc & ~l_we & (l_size == 2'b01);
  assign mem_address = acc ? l_addr : '0;
  assign mem_writeData = acc ? l_wdata : '0;
  assign rsp0_valid = (state == RESP) & ~gid;
  assign rsp1_valid = (state == RESP) & gid;
  assign rsp0_rdata = rsp0_valid ? l_rdata : '0;
  assign rsp1_rdata = rsp1_valid ? l_rdata : '0;
  assign rsp0_err = rsp0_valid & l_err;
  assign rsp1_err = rsp1_valid & l_err;
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: random and directed checks of the arbiter against a transaction-level model
module tb_dm_port_arbiter;
  logic clk = 1'b0, rst_n = 1'b1;
  logic req0_valid, req0_ready, req0_we, rsp0_valid, rsp0_ready, rsp0_err;
  logic req1_valid, req1_ready, req1_we, rsp1_valid, rsp1_ready, rsp1_err;
  logic [1:0] req0_size, req1_size;
  logic [31:0] req0_addr, req0_wdata, rsp0_rdata, req1_addr, req1_wdata, rsp1_rdata;
  logic mem_wren, mem_sb, mem_lb, mem_lbu;
  logic [31:0] mem_address, mem_writeData, mem_readData;
  always #5 clk = ~clk;

  dm_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_size(req0_size),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_size(req1_size),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_wren(mem_wren), .mem_sb(mem_sb), .mem_lb(mem_lb), .mem_lbu(mem_lbu),
    .mem_address(mem_address), .mem_writeData(mem_writeData), .mem_readData(mem_readData)
  );

  // data memory the DUT drives: combinational read, posedge write
  logic [7:0] mem [0:4095];
  logic [7:0] ref_mem [0:4095];
  logic init_done = 1'b0;
  logic [11:0] ma, mw;
  always_comb begin
    ma = mem_address[11:0];
    mw = {ma[11:2], 2'b00};
    if (mem_address >= 32'd4096) mem_readData = 32'hBAD0BAD0;
    else if (mem_lb) mem_readData = {{24{mem[ma][7]}}, mem[ma]};
    else if (mem_lbu) mem_readData = {24'h0, mem[ma]};
    else mem_readData = {mem[mw + 12'd3], mem[mw + 12'd2], mem[mw + 12'd1], mem[mw]};
  end
  always @(posedge clk) begin
    if (!init_done) for (int i = 0; i < 4096; i++) mem[i] <= 8'(i * 37 + 5);
    else if (mem_wren && mem_address < 32'd4096) begin
      if (mem_sb) mem[ma] <= mem_writeData[7:0];
      else begin
        mem[mw] <= mem_writeData[7:0];
        mem[mw + 12'd1] <= mem_writeData[15:8];
        mem[mw + 12'd2] <= mem_writeData[23:16];
        mem[mw + 12'd3] <= mem_writeData[31:24];
      end
    end
  end

  int passed = 0, total = 0;
  // transaction-level model: one command in flight, its age in cycles since acceptance
  bit in_flight = 0, last_g = 1, t_id, t_we, t_err, accepted, completed, acc_id;
  int age = 0, wren_cycles = 0;
  logic [1:0] t_size;
  logic [31:0] t_addr, t_wdata, t_rdata, obs_rdata;
  logic obs_err;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  function automatic bit winner();
    return (req0_valid && req1_valid) ? !last_g : req1_valid;
  endfunction

  function automatic logic [31:0] ref_load(logic [1:0] size, logic [31:0] a);
    logic [11:0] b = a[11:0];
    if (size == 2'd0) return {{24{ref_mem[b][7]}}, ref_mem[b]};
    if (size == 2'd1) return {24'h0, ref_mem[b]};
    return {ref_mem[b + 12'd3], ref_mem[b + 12'd2], ref_mem[b + 12'd1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    return r < 7 ? 32'($urandom_range(0, 63)) : r < 9 ? 32'($urandom_range(4088, 4100)) : $urandom;
  endfunction

  task automatic compare();
    bit act, rsp, w;
    act = rst_n && in_flight && age == 1;
    rsp = rst_n && in_flight && age >= 2;
    w = winner();
    chk("req0_ready", req0_ready, rst_n && !in_flight && req0_valid && !w);
    chk("req1_ready", req1_ready, rst_n && !in_flight && req1_valid && w);
    chk("rsp0_valid", rsp0_valid, rsp && !t_id);
    chk("rsp1_valid", rsp1_valid, rsp && t_id);
    if (rsp) begin
      obs_rdata = t_id ? rsp1_rdata : rsp0_rdata;
      obs_err = t_id ? rsp1_err : rsp0_err;
      chk("rsp_rdata", obs_rdata, t_rdata);
      chk("rsp_err", obs_err, t_err);
    end else if (!rst_n) begin
      chk("rst_rdata", rsp0_rdata | rsp1_rdata, 0);
      chk("rst_err", rsp0_err | rsp1_err, 0);
    end
    chk("mem_wren", mem_wren, act && t_we && !t_err);
    chk("mem_sb", mem_sb, act && t_we && !t_size[1]);
    chk("mem_lb", mem_lb, act && !t_we && t_size == 2'd0);
    chk("mem_lbu", mem_lbu, act && !t_we && t_size == 2'd1);
    chk("mem_address", mem_address, act ? t_addr : 32'h0);
    chk("mem_writeData", mem_writeData, act ? t_wdata : 32'h0);
    wren_cycles += int'(mem_wren);
  endtask

  // advance the model across the coming clock edge using the inputs now applied
  task automatic model_update();
    accepted = 0;
    completed = 0;
    if (!rst_n) begin
      in_flight = 0;
      last_g = 1;
    end else if (!in_flight) begin
      if (req0_valid || req1_valid) begin
        t_id = winner();
        t_we = t_id ? req1_we : req0_we;
        t_size = t_id ? req1_size : req0_size;
        t_addr = t_id ? req1_addr : req0_addr;
        t_wdata = t_id ? req1_wdata : req0_wdata;
        t_err = t_addr >= 4096 || t_size == 2'd3 || (t_size == 2'd2 && t_addr % 4 != 0);
        t_rdata = (t_we || t_err) ? 32'h0 : ref_load(t_size, t_addr);
        if (t_we && !t_err) begin
          ref_mem[t_addr[11:0]] = t_wdata[7:0];
          if (t_size == 2'd2) for (int k = 1; k < 4; k++) ref_mem[t_addr[11:0] + 12'(k)] = t_wdata[8*k +: 8];
        end
        last_g = t_id;
        in_flight = 1;
        age = 1;
        accepted = 1;
        acc_id = t_id;
      end
    end else if (age == 1) age = 2;
    else if (t_id ? rsp1_ready : rsp0_ready) begin
      in_flight = 0;
      completed = 1;
    end
  endtask

  task automatic step();
    #1;
    compare();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_req(int p);
    req0_valid = $urandom_range(0, 99) < p;
    req1_valid = $urandom_range(0, 99) < p;
    req0_we = 1'($urandom_range(0, 1));
    req1_we = 1'($urandom_range(0, 1));
    req0_size = 2'($urandom_range(0, 3));
    req1_size = 2'($urandom_range(0, 3));
    req0_addr = rand_addr();
    req1_addr = rand_addr();
    req0_wdata = $urandom;
    req1_wdata = $urandom;
  endtask

  task automatic txn(bit id, bit we, logic [1:0] size, logic [31:0] addr, logic [31:0] wdata,
                     output logic [31:0] rd, output logic er);
    int n = 0;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    if (id) begin req1_valid = 1; req1_we = we; req1_size = size; req1_addr = addr; req1_wdata = wdata; end
    else begin req0_valid = 1; req0_we = we; req0_size = size; req0_addr = addr; req0_wdata = wdata; end
    wren_cycles = 0;
    do begin step(); n++; end while (!accepted && n < 20);
    chk("txn_accept", accepted, 1);
    req0_valid = 0; req1_valid = 0;
    n = 0;
    while (!completed && n < 20) begin step(); n++; end
    chk("txn_latency", n, 2);
    rd = obs_rdata;
    er = obs_err;
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    bit g[$];
    int n;
    req0_valid = 0; req1_valid = 0; req0_we = 0; req1_we = 0; req0_size = 0; req1_size = 0;
    req0_addr = 0; req1_addr = 0; req0_wdata = 0; req1_wdata = 0; rsp0_ready = 0; rsp1_ready = 0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'(i * 37 + 5);
    #1 rst_n = 0;
    step();
    step();
    init_done = 1;
    rst_n = 1;
    // directed loads and stores with hand-computed results
    txn(0, 1, 2'd2, 32'h20, 32'hDEADBEEF, rd, er);
    chk("sw_wren_cycles", wren_cycles, 1); chk("sw_err", er, 0);
    txn(0, 0, 2'd2, 32'h20, 0, rd, er);
    chk("lw_20", rd, 32'hDEADBEEF); chk("lw_20_err", er, 0);
    txn(0, 1, 2'd0, 32'h21, 32'h80, rd, er);
    txn(0, 0, 2'd0, 32'h21, 0, rd, er); chk("lb_21", rd, 32'hFFFFFF80);
    txn(0, 0, 2'd1, 32'h21, 0, rd, er); chk("lbu_21", rd, 32'h00000080);
    txn(0, 0, 2'd2, 32'h20, 0, rd, er); chk("lw_20_merged", rd, 32'hDEAD80EF);
    txn(1, 0, 2'd2, 32'h1000, 0, rd, er); chk("lw_1000_err", er, 1); chk("lw_1000_rdata", rd, 0);
    txn(1, 1, 2'd2, 32'h22, 32'h12345678, rd, er); chk("sw_22_err", er, 1); chk("sw_22_wren", wren_cycles, 0);
    txn(0, 0, 2'd2, 32'h20, 0, rd, er); chk("lw_20_unchanged", rd, 32'hDEAD80EF);
    txn(1, 0, 2'd3, 32'h24, 0, rd, er); chk("size3_err", er, 1);
    txn(1, 0, 2'd1, 32'd4095, 0, rd, er); chk("lbu_4095_err", er, 0); chk("lbu_4095", rd, 32'h000000E0);
    txn(1, 0, 2'd0, 32'd4096, 0, rd, er); chk("lb_4096_err", er, 1); chk("lb_4096_rdata", rd, 0);
    txn(1, 1, 2'd2, 32'd4092, 32'hCAFEF00D, rd, er); chk("sw_4092_err", er, 0); chk("sw_4092_wren", wren_cycles, 1);
    txn(0, 0, 2'd2, 32'd4092, 0, rd, er); chk("lw_4092", rd, 32'hCAFEF00D);
    // response backpressure on requester 1 while requester 0 waits
    req1_valid = 1; req1_we = 0; req1_size = 2'd2; req1_addr = 32'h20; rsp1_ready = 0; rsp0_ready = 1;
    n = 0;
    do begin step(); n++; end while (!accepted && n < 10);
    chk("bp_accept", accepted, 1);
    req1_valid = 0; req0_valid = 1; req0_we = 0; req0_size = 2'd2; req0_addr = 32'h24;
    repeat (6) step();
    chk("bp_rdata", obs_rdata, 32'hDEAD80EF);
    chk("bp_valid_held", rsp1_valid, 1);
    rsp1_ready = 1;
    step();
    chk("bp_done", completed, 1);
    step();
    chk("bp_regrant", accepted && acc_id == 0, 1);
    req0_valid = 0;
    repeat (4) step();
    // asynchronous reset in the middle of a response
    req0_valid = 1; req0_we = 0; req0_size = 2'd2; req0_addr = 32'h20; rsp0_ready = 0;
    n = 0;
    do begin step(); n++; end while (!accepted && n < 10);
    req0_valid = 0; req1_valid = 1; req1_we = 0; req1_size = 2'd0; req1_addr = 0;
    step();
    step();
    chk("pre_rst_valid", rsp0_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_rsp_valid", rsp0_valid, 0);
    chk("rst_ready", req1_ready, 0);
    chk("rst_mem", {mem_wren, mem_sb, mem_lb, mem_lbu, mem_address != 0}, 0);
    compare();
    model_update();
    @(posedge clk);
    @(negedge clk);
    step();
    rst_n = 1;
    // contention from reset: grants must alternate starting with requester 0
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (16) begin
      rand_req(100);
      step();
      if (accepted) g.push_back(acc_id);
    end
    chk("cont_count", g.size() >= 4, 1);
    for (int i = 0; i < 4; i++) chk("cont_grant", i < g.size() ? g[i] : 1'bx, i % 2);
    // random traffic with random response backpressure
    repeat (3000) begin
      rand_req(50);
      rsp0_ready = $urandom_range(0, 3) != 0;
      rsp1_ready = $urandom_range(0, 3) != 0;
      step();
    end
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    repeat (5) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
